// File: rtl/add4_rr_sched_pkg.sv
// Shared defaults, derived widths and FSM encoding for the round-robin adder scheduler.
package add4_sched_pkg;

    localparam int DEF_DW      = 8;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_ADD_LAT = 2;
    localparam int SUM_W       = DEF_DW + 2;
    localparam int IDX_W       = $clog2(DEF_N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    function automatic int wrap_inc(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/add4_rr_sched_if.sv
// Requester, adder and response signals of the scheduler; master is the environment side.
interface add4_rr_sched_if
    import add4_sched_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int N_REQ = DEF_N_REQ
);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*4*DW-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  add_enable;
    logic [DW-1:0]         add_a;
    logic [DW-1:0]         add_b;
    logic [DW-1:0]         add_c;
    logic [DW-1:0]         add_d;
    logic [DW+1:0]         add_sum;
    logic [N_REQ-1:0]      rsp_valid;
    logic [DW+1:0]         rsp_sum;

    modport master (
        output req_valid, req_data, add_sum,
        input  req_ready, add_enable, add_a, add_b, add_c, add_d, rsp_valid, rsp_sum
    );

    modport slave (
        input  req_valid, req_data, add_sum,
        output req_ready, add_enable, add_a, add_b, add_c, add_d, rsp_valid, rsp_sum
    );

endinterface

// File: rtl/add4_rr_sched_rr_arb_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_arb_pick
    import add4_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = i_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_any && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                o_any        = 1'b1;
            end
            w_pos = IW'(wrap_inc(int'(w_pos), N_REQ));
        end
    end

endmodule

// File: rtl/add_4_nums.sv
// Pipelined four-operand adder: operands captured on enable, sum valid LAT edges later.
module add_4_nums #(
    parameter int DW  = 8,
    parameter int LAT = 2
) (
    input  logic          r_clk,
    input  logic          i_enable,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    input  logic [DW-1:0] i_d,
    output logic [DW+1:0] o_sum
);

    logic [DW-1:0] r_a, r_b, r_c, r_d;
    logic [DW+1:0] r_sum_pipe [LAT];

    always_ff @(posedge r_clk) begin
        if (i_enable) begin
            r_a <= i_a;
            r_b <= i_b;
            r_c <= i_c;
            r_d <= i_d;
        end
        r_sum_pipe[0] <= {2'b00, r_a} + {2'b00, r_b} + {2'b00, r_c} + {2'b00, r_d};
        for (int i = 1; i < LAT; i++) begin
            r_sum_pipe[i] <= r_sum_pipe[i-1];
        end
    end

    assign o_sum = r_sum_pipe[LAT-1];

endmodule

// File: rtl/add4_rr_sched.sv
// Shares one four-operand adder among N_REQ requesters; tags ride alongside the adder
// pipeline so each returned sum is routed back as a one-hot response pulse.
module add4_rr_sched
    import add4_sched_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic              r_clk,
    input  logic              r_rst_n,
    input  logic              i_enable,
    output logic              o_busy,
    add4_rr_sched_if.slave    sched_bus
);

    localparam int SW = DW + 2;
    localparam int IW = $clog2(N_REQ);
    // Issue register, adder input capture and ADD_LAT adder stages, then the response register.
    localparam int TAG_D = ADD_LAT + 2;

    sched_state_t        r_state;
    logic [IW-1:0]       r_ptr;
    logic                r_busy;
    logic                r_add_en;
    logic [DW-1:0]       r_add_a, r_add_b, r_add_c, r_add_d;
    logic [TAG_D-1:0]    r_tag_vld;
    logic [IW-1:0]       r_tag_idx [TAG_D];
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [SW-1:0]       r_rsp_sum;

    logic [N_REQ-1:0]    w_gnt;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_gnt_any;
    logic                w_grant_ok;
    logic                w_accept;
    logic                w_pipe_busy;
    logic [4*DW-1:0]     w_req_ops [N_REQ];
    logic [4*DW-1:0]     w_sel_ops;

    for (genvar k = 0; k < N_REQ; k++) begin : g_ops
        assign w_req_ops[k] = sched_bus.req_data[k*4*DW +: 4*DW];
    end

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req (sched_bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    assign w_grant_ok          = r_rst_n && i_enable && (r_state != DRAIN);
    assign w_accept            = w_grant_ok && w_gnt_any;
    assign w_sel_ops           = w_req_ops[w_gnt_idx];
    assign w_pipe_busy         = |r_tag_vld;
    assign sched_bus.req_ready = w_grant_ok ? w_gnt : '0;

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
            r_add_en    <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_c     <= '0;
            r_add_d     <= '0;
            r_tag_vld   <= '0;
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
        end else begin
            r_add_en  <= w_accept;
            r_tag_vld <= {r_tag_vld[TAG_D-2:0], w_accept};
            if (w_accept) begin
                r_add_a <= w_sel_ops[0*DW +: DW];
                r_add_b <= w_sel_ops[1*DW +: DW];
                r_add_c <= w_sel_ops[2*DW +: DW];
                r_add_d <= w_sel_ops[3*DW +: DW];
                r_ptr   <= IW'(wrap_inc(int'(w_gnt_idx), N_REQ));
            end
            r_rsp_valid <= r_tag_vld[TAG_D-1] ? (N_REQ'(1) << r_tag_idx[TAG_D-1]) : '0;
            if (r_tag_vld[TAG_D-1]) begin
                r_rsp_sum <= sched_bus.add_sum;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!i_enable && w_pipe_busy) begin
                        r_state <= DRAIN;
                    end else if (!w_accept && !w_pipe_busy) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (i_enable) begin
                        r_state <= RUN;
                    end else if (!w_pipe_busy) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tag indices are qualified by r_tag_vld, so they need no reset.
    always_ff @(posedge r_clk) begin
        r_tag_idx[0] <= w_gnt_idx;
        for (int i = 1; i < TAG_D; i++) begin
            r_tag_idx[i] <= r_tag_idx[i-1];
        end
    end

    assign sched_bus.add_enable = r_add_en;
    assign sched_bus.add_a      = r_add_a;
    assign sched_bus.add_b      = r_add_b;
    assign sched_bus.add_c      = r_add_c;
    assign sched_bus.add_d      = r_add_d;
    assign sched_bus.rsp_valid  = r_rsp_valid;
    assign sched_bus.rsp_sum    = r_rsp_sum;
    assign o_busy               = r_busy;

endmodule

// File: tb/tb_add4_rr_sched.sv
// Directed bench: scheduler paired with the pipelined adder, table-driven grant/response checks.
module tb_add4_rr_sched;
    import add4_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NV = 15;
    localparam logic [127:0] DROT = {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};

    typedef struct {
        logic [N-1:0]       vld;
        logic [N*4*DW-1:0]  data;
        logic [N-1:0]       exp_rdy;
        logic [SUM_W-1:0]   exp_sum;
    } vec_t;

    logic r_clk;
    logic r_rst_n;
    logic i_enable;
    logic o_busy;
    int   errors = 0;
    int   checks = 0;
    vec_t tv [NV];

    add4_rr_sched_if #(.DW(DW), .N_REQ(N)) sif ();

    add4_rr_sched #(.DW(DW), .N_REQ(N), .ADD_LAT(2)) dut (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .i_enable  (i_enable),
        .o_busy    (o_busy),
        .sched_bus (sif)
    );

    add_4_nums #(.DW(DW), .LAT(2)) u_adder (
        .r_clk    (r_clk),
        .i_enable (sif.add_enable),
        .i_a      (sif.add_a),
        .i_b      (sif.add_b),
        .i_c      (sif.add_c),
        .i_d      (sif.add_d),
        .o_sum    (sif.add_sum)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{4'b0100, {32'h0, 32'h04030201, 64'h0}, 4'b0100, 10'd10};
        tv[1]  = '{4'b1000, {32'hFFFFFFFF, 96'h0},        4'b1000, 10'd1020};
        tv[2]  = '{4'b1111, DROT, 4'b0001, 10'd4};
        tv[3]  = '{4'b1111, DROT, 4'b0010, 10'd8};
        tv[4]  = '{4'b1111, DROT, 4'b0100, 10'd12};
        tv[5]  = '{4'b1111, DROT, 4'b1000, 10'd16};
        tv[6]  = '{4'b1111, DROT, 4'b0001, 10'd4};
        tv[7]  = '{4'b1111, DROT, 4'b0010, 10'd8};
        tv[8]  = '{4'b1111, DROT, 4'b0100, 10'd12};
        tv[9]  = '{4'b1111, DROT, 4'b1000, 10'd16};
        tv[10] = '{4'b0000, DROT, 4'b0000, 10'd0};
        tv[11] = '{4'b1010, DROT, 4'b0010, 10'd8};
        tv[12] = '{4'b0011, DROT, 4'b0001, 10'd4};
        tv[13] = '{4'b0001, DROT, 4'b0001, 10'd4};
        tv[14] = '{4'b0011, DROT, 4'b0010, 10'd8};

        // Reset held with every requester asking.
        r_rst_n       = 1'b0;
        i_enable      = 1'b1;
        sif.req_valid = 4'b1111;
        sif.req_data  = DROT;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("rst_rdy[%0d]", i), 32'(sif.req_ready), 32'h0);
            @(posedge r_clk); #1;
            chk($sformatf("rst_busy[%0d]", i), 32'(o_busy), 32'h0);
            chk($sformatf("rst_aen[%0d]", i), 32'(sif.add_enable), 32'h0);
            chk($sformatf("rst_rspv[%0d]", i), 32'(sif.rsp_valid), 32'h0);
            chk($sformatf("rst_rsps[%0d]", i), 32'(sif.rsp_sum), 32'h0);
        end
        r_rst_n       = 1'b1;
        sif.req_valid = '0;

        // Vector table: grant checked combinationally, response four edges after accept.
        for (int j = 0; j < NV + 4; j++) begin
            if (j < NV) begin
                sif.req_valid = tv[j].vld;
                sif.req_data  = tv[j].data;
            end else begin
                sif.req_valid = '0;
            end
            #1;
            if (j < NV) chk($sformatf("rdy[%0d]", j), 32'(sif.req_ready), 32'(tv[j].exp_rdy));
            @(posedge r_clk); #1;
            if (j < NV) chk($sformatf("aen[%0d]", j), 32'(sif.add_enable), 32'(tv[j].exp_rdy != 0));
            if (j >= 4) begin
                chk($sformatf("rspv[%0d]", j - 4), 32'(sif.rsp_valid), 32'(tv[j-4].exp_rdy));
                if (tv[j-4].exp_rdy != 0)
                    chk($sformatf("rsps[%0d]", j - 4), 32'(sif.rsp_sum), 32'(tv[j-4].exp_sum));
            end
        end
        repeat (2) @(posedge r_clk);
        #1 chk("idle_busy", 32'(o_busy), 32'h0);

        // Two ops in flight, then i_enable drops while everyone is asking.
        sif.req_data  = DROT;
        sif.req_valid = 4'b0001;
        #1 chk("en_rdy0", 32'(sif.req_ready), 32'h1);
        @(posedge r_clk); #1;
        #1 chk("en_rdy1", 32'(sif.req_ready), 32'h1);
        @(posedge r_clk); #1;
        i_enable      = 1'b0;
        sif.req_valid = 4'b1111;
        #1 chk("en_drop_rdy", 32'(sif.req_ready), 32'h0);
        for (int k = 2; k <= 7; k++) begin
            @(posedge r_clk); #1;
            chk($sformatf("drain_rspv[%0d]", k), 32'(sif.rsp_valid), (k == 4 || k == 5) ? 32'h1 : 32'h0);
            if (k == 4 || k == 5) chk($sformatf("drain_rsps[%0d]", k), 32'(sif.rsp_sum), 32'd4);
            chk($sformatf("drain_busy[%0d]", k), 32'(o_busy), (k <= 5) ? 32'h1 : 32'h0);
            chk($sformatf("drain_rdy[%0d]", k), 32'(sif.req_ready), 32'h0);
        end
        i_enable      = 1'b1;
        sif.req_valid = '0;
        @(posedge r_clk); #1;

        // Reset one cycle after an accept: the op vanishes and the pointer restarts at 0.
        sif.req_data  = {32'h0, 32'h04030201, 64'h0};
        sif.req_valid = 4'b0100;
        #1 chk("mid_rdy", 32'(sif.req_ready), 32'h4);
        @(posedge r_clk); #1;
        r_rst_n       = 1'b0;
        sif.req_valid = 4'b1111;
        #1 chk("mid_rst_rdy", 32'(sif.req_ready), 32'h0);
        @(posedge r_clk); #1;
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        chk("mid_rst_aen", 32'(sif.add_enable), 32'h0);
        r_rst_n       = 1'b1;
        sif.req_data  = {32'h06060606, 32'h05050505, 64'h0};
        sif.req_valid = 4'b1100;
        #1 chk("post_rst_rdy", 32'(sif.req_ready), 32'h4);
        @(posedge r_clk); #1;
        sif.req_valid = '0;
        for (int k = 3; k <= 6; k++) begin
            @(posedge r_clk); #1;
            chk($sformatf("post_rst_rspv[%0d]", k), 32'(sif.rsp_valid), (k == 6) ? 32'h4 : 32'h0);
            if (k == 6) chk("post_rst_rsps", 32'(sif.rsp_sum), 32'd20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
